// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE FSM over a 4-digit BCD count (SS.cc) advanced by tick_in rising edges.
// Optional lap-freeze display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int unsigned SEC_TENS_MAX = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_in,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] disp,
  output logic        running,
  output logic        ovf,
  output logic        lap_hold
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t      state, state_nx;
  logic        tick_d;
  logic        tick_rise;
  logic [3:0]  d3, d2, d1, d0;
  logic [3:0]  n3, n2, n1, n0;
  logic        wrap;
  logic [15:0] count_nx;
  logic [15:0] disp_nx;
  logic        hold_nx;

  assign tick_rise = tick_in & ~tick_d;
  assign count_nx  = {n3, n2, n1, n0};

  always_comb begin
    n3   = d3;
    n2   = d2;
    n1   = d1;
    n0   = d0;
    wrap = 1'b0;
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = clear ? IDLE : (start_stop ? RUN : IDLE);
      RUN:     state_nx = start_stop ? PAUSE : RUN;
      PAUSE:   state_nx = clear ? IDLE : (start_stop ? RUN : PAUSE);
      default: state_nx = IDLE;
    endcase
    if ((state == IDLE || state == PAUSE) && clear) begin
      n3 = '0;
      n2 = '0;
      n1 = '0;
      n0 = '0;
    end else if (state == RUN && tick_rise) begin
      // Ripple-carry through the BCD digits; only the top digit uses the parameterised limit
      if (d0 != 4'd9) n0 = d0 + 4'd1;
      else begin
        n0 = '0;
        if (d1 != 4'd9) n1 = d1 + 4'd1;
        else begin
          n1 = '0;
          if (d2 != 4'd9) n2 = d2 + 4'd1;
          else begin
            n2 = '0;
            if (d3 != 4'(SEC_TENS_MAX)) n3 = d3 + 4'd1;
            else begin
              n3   = '0;
              wrap = 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [15:0] lap_cap, lap_cap_nx;

  always_comb begin
    hold_nx    = lap_hold;
    lap_cap_nx = lap_cap;
    if (state == RUN) begin
      if (start_stop) hold_nx = 1'b0;
      else if (lap) begin
        hold_nx = ~lap_hold;
        if (!lap_hold) lap_cap_nx = count_nx;
      end
    end
    disp_nx = hold_nx ? lap_cap_nx : count_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lap_cap <= '0;
    else        lap_cap <= lap_cap_nx;
  end
`else
  logic unused_lap;
  assign unused_lap = lap;

  always_comb begin
    hold_nx = 1'b0;
    disp_nx = count_nx;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_d   <= 1'b0;
      d3       <= '0;
      d2       <= '0;
      d1       <= '0;
      d0       <= '0;
      disp     <= '0;
      running  <= 1'b0;
      ovf      <= 1'b0;
      lap_hold <= 1'b0;
    end else begin
      state    <= state_nx;
      tick_d   <= tick_in;
      d3       <= n3;
      d2       <= n2;
      d1       <= n1;
      d0       <= n0;
      disp     <= disp_nx;
      running  <= (state_nx == RUN);
      ovf      <= wrap;
      lap_hold <= hold_nx;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomised self-checking bench for stopwatch_ctrl against a centisecond-integer reference model.
module tb_stopwatch_ctrl;

  localparam int SEC_TENS_MAX = 5;
  localparam int WRAP_CS      = (SEC_TENS_MAX + 1) * 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_in = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic [15:0] disp;
  logic        running, ovf, lap_hold;

  stopwatch_ctrl #(.SEC_TENS_MAX(SEC_TENS_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .start_stop(start_stop),
    .clear(clear), .lap(lap), .disp(disp), .running(running), .ovf(ovf),
    .lap_hold(lap_hold)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 run, 2 pause; count held as plain centiseconds
  int m_mode = 0;
  int m_cs = 0;
  int m_cap = 0;
  bit m_hold = 0;
  bit m_tick_d = 0;
  bit m_ovf = 0;
  bit tk_level = 0;
  int exp_ovf = 0;
  int ovf_seen = 0;

  function automatic logic [15:0] bcd(input int v);
    bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] exp_disp();
    exp_disp = bcd(m_hold ? m_cap : m_cs);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cs = 0; m_cap = 0; m_hold = 0; m_tick_d = 0; m_ovf = 0;
  endtask

  task automatic model_update(input bit ss, input bit clr, input bit lp, input bit tk);
    bit rise;
    rise = tk & ~m_tick_d;
    m_tick_d = tk;
    m_ovf = 0;
    if (m_mode == 1) begin
      if (rise) begin
        m_cs++;
        if (m_cs == WRAP_CS) begin
          m_cs = 0;
          m_ovf = 1;
          exp_ovf++;
        end
      end
`ifdef STOPWATCH_LAP_EN
      if (ss) m_hold = 0;
      else if (lp) begin
        m_hold = !m_hold;
        if (m_hold) m_cap = m_cs;
      end
`endif
      if (ss) m_mode = 2;
    end else begin
      if (clr) begin
        m_mode = 0;
        m_cs = 0;
      end else if (ss) m_mode = 1;
    end
  endtask

  task automatic step(input bit ss, input bit clr, input bit lp);
    start_stop = ss; clear = clr; lap = lp; tick_in = tk_level;
    @(posedge clk);
    model_update(ss, clr, lp, tk_level);
    #1;
    start_stop = 0; clear = 0; lap = 0;
    if (ovf) ovf_seen++;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tk_level = 1;
      repeat ($urandom_range(1, 2)) step(0, 0, 0);
      tk_level = 0;
      repeat ($urandom_range(1, 2)) step(0, 0, 0);
    end
  endtask

  task automatic to_idle();
    if (m_mode == 1) step(1, 0, 0);
    step(0, 1, 0);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_disp: got %h expected %h", disp, 16'h0000); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (lap_hold !== 1'b0) begin errors++; $display("FAIL reset_lap_hold: got %b expected 0", lap_hold); end
    @(negedge clk);
    rst_n = 1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_count_250();
    int ovf0;
    ovf0 = ovf_seen;
    step(1, 0, 0);
    do_ticks(250);
    checks++; if (disp !== 16'h0250 || disp !== exp_disp()) begin errors++; $display("FAIL count250_disp: got %h expected %h", disp, 16'h0250); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL count250_running: got %b expected 1", running); end
    checks++; if (ovf_seen != ovf0) begin errors++; $display("FAIL count250_ovf: got %0d pulses expected 0", ovf_seen - ovf0); end
  endtask

  task automatic test_wrap();
    int ovf0, e0;
    to_idle();
    step(1, 0, 0);
    do_ticks(5999);
    checks++; if (disp !== 16'h5999) begin errors++; $display("FAIL wrap_pre: got %h expected %h", disp, 16'h5999); end
    ovf0 = ovf_seen; e0 = exp_ovf;
    do_ticks(1);
    step(0, 0, 0);
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL wrap_disp: got %h expected %h", disp, 16'h0000); end
    checks++; if (ovf_seen - ovf0 != 1 || exp_ovf - e0 != 1) begin errors++; $display("FAIL wrap_ovf_cycles: got %0d expected 1", ovf_seen - ovf0); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL wrap_running: got %b expected 1", running); end
  endtask

  task automatic test_pause_coincident();
    to_idle();
    step(1, 0, 0);
    do_ticks(7);
    tk_level = 1;
    step(1, 0, 0);
    tk_level = 0;
    step(0, 0, 0);
    checks++; if (disp !== 16'h0008 || disp !== exp_disp()) begin errors++; $display("FAIL pause_edge_disp: got %h expected %h", disp, 16'h0008); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_edge_running: got %b expected 0", running); end
    do_ticks(5);
    checks++; if (disp !== 16'h0008) begin errors++; $display("FAIL pause_hold_disp: got %h expected %h", disp, 16'h0008); end
  endtask

  task automatic test_clear_combo();
    to_idle();
    step(1, 0, 0);
    do_ticks(1234);
    step(1, 0, 0);
    checks++; if (disp !== 16'h1234) begin errors++; $display("FAIL pause_1234: got %h expected %h", disp, 16'h1234); end
    step(1, 1, 0);
    checks++; if (disp !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL ss_clr_combo: got %h/%b expected 0000/0", disp, running); end
    step(1, 0, 0);
    do_ticks(3);
    step(0, 1, 0);
    checks++; if (disp !== 16'h0003 || running !== 1'b1) begin errors++; $display("FAIL clear_in_run: got %h/%b expected 0003/1", disp, running); end
  endtask

  task automatic test_reset_midrun();
    to_idle();
    step(1, 0, 0);
    do_ticks(321);
    checks++; if (disp !== 16'h0321) begin errors++; $display("FAIL midrun_pre: got %h expected %h", disp, 16'h0321); end
    #2 rst_n = 0;
    #1;
    checks++; if (disp !== 16'h0000 || running !== 1'b0 || ovf !== 1'b0 || lap_hold !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %h/%b/%b/%b expected 0000/0/0/0", disp, running, ovf, lap_hold);
    end
    model_reset();
    tk_level = 1;
    tick_in = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 0);
    tk_level = 0;
    step(0, 0, 0);
    do_ticks(10);
    checks++; if (disp !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL post_reset_ticks: got %h/%b expected 0000/0", disp, running); end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    to_idle();
    step(1, 0, 0);
    do_ticks(100);
    step(0, 0, 1);
    do_ticks(50);
    checks++; if (disp !== 16'h0100 || lap_hold !== 1'b1) begin errors++; $display("FAIL lap_freeze: got %h/%b expected 0100/1", disp, lap_hold); end
    step(0, 0, 1);
    checks++; if (disp !== 16'h0150 || lap_hold !== 1'b0) begin errors++; $display("FAIL lap_release: got %h/%b expected 0150/0", disp, lap_hold); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) tk_level = !tk_level;
      step($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      checks++; if (disp !== exp_disp()) begin errors++; $display("FAIL rand_disp[%0d]: got %h expected %h", i, disp, exp_disp()); end
      checks++; if (running !== (m_mode == 1)) begin errors++; $display("FAIL rand_running[%0d]: got %b expected %b", i, running, m_mode == 1); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rand_ovf[%0d]: got %b expected %b", i, ovf, m_ovf); end
      checks++; if (lap_hold !== m_hold) begin errors++; $display("FAIL rand_lap_hold[%0d]: got %b expected %b", i, lap_hold, m_hold); end
    end
  endtask

  initial begin
    test_reset();
    test_count_250();
    test_wrap();
    test_pause_coincident();
    test_clear_combo();
    test_reset_midrun();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter: SEC_TENS_MAX, default 5, highest tens-of-seconds digit before wrap; legal range 1..9.
REQ-002 SHALL have port: clk  input  1  system clock, same clock that drives the upstream clock divider.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: tick_in  input  1  100 Hz square wave (clk_100) from the clock divider, synchronous to clk.
REQ-005 SHALL have port: start_stop  input  1  single-cycle pulse, debounced upstream.
REQ-006 SHALL have port: clear  input  1  single-cycle pulse.
REQ-007 SHALL have port: lap  input  1  single-cycle pulse; used only when LAP_EN is defined.
REQ-008 SHALL have port: disp  output  16  BCD display {sec_tens, sec_ones, csec_tens, csec_ones}, each 4 bits.
REQ-009 SHALL have port: running  output  1  high while the FSM is in RUN.
REQ-010 SHALL have port: ovf  output  1  one-cycle pulse on count wrap.
REQ-011 SHALL have port: lap_hold  output  1  high while the display is frozen.

Function
REQ-012 SHALL register tick_in into tick_d each clk; tick_rise = tick_in & ~tick_d (combinational, one cycle wide per tick_in rising edge).
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE with encoding 2'b00, 2'b01, 2'b10; the state 2'b11 SHALL recover to IDLE on the next clk.
REQ-014 SHALL transition: IDLE + start_stop -> RUN; RUN + start_stop -> PAUSE; PAUSE + start_stop -> RUN.
REQ-015 SHALL transition: IDLE or PAUSE + clear -> IDLE, with all four count digits zeroed on the same edge.
REQ-016 SHALL ignore clear while in RUN.
REQ-017 SHALL, when start_stop and clear are asserted in the same cycle, let clear win in IDLE/PAUSE (next state IDLE) and let start_stop win in RUN (next state PAUSE).
REQ-018 SHALL increment the count on the clk edge where tick_rise=1 and the current state is RUN; the new value SHALL be visible on disp in the following cycle.
REQ-019 SHALL count a tick_rise coincident with RUN->PAUSE; SHALL NOT count a tick_rise coincident with PAUSE->RUN or IDLE->RUN.
REQ-020 SHALL perform BCD arithmetic: each digit 0..9; carry csec_ones -> csec_tens -> sec_ones -> sec_tens; no digit SHALL ever hold a value of 10 or more.
REQ-021 SHALL wrap sec_tens from SEC_TENS_MAX to 0 (default: 59.99 -> 00.00); on that edge ovf SHALL pulse for exactly one cycle and the FSM SHALL stay in RUN.
REQ-022 SHALL hold the count constant in IDLE and PAUSE regardless of tick_rise.
REQ-023 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-024 SHALL, on rst_n=0, asynchronously force: state=IDLE, all digits=0, tick_d=0, disp=16'h0000, running=0, ovf=0, lap_hold=0.
REQ-025 SHALL, on reset mid-RUN, discard the count; after rst_n deassertion, the first tick_rise SHALL NOT be counted until start_stop is received.
REQ-026 SHALL, because tick_d resets to 0, treat tick_in=1 at reset release as a rising edge; this is harmless because the state is IDLE.

Configuration
REQ-027 SHALL support macro STOPWATCH_LAP_EN.
REQ-028 SHALL, when STOPWATCH_LAP_EN is defined: a lap pulse in RUN toggles lap_hold; while lap_hold=1, disp shows the count captured on the lap edge and the internal count continues.
REQ-029 SHALL, when STOPWATCH_LAP_EN is defined: leaving RUN (start_stop) clears lap_hold on the same edge; lap in IDLE/PAUSE is ignored.
REQ-030 SHALL, when STOPWATCH_LAP_EN is not defined: ignore the lap input, tie lap_hold to 0, and make disp always equal the live count; no lap capture registers are synthesized.

Verification
REQ-031 SHALL cover: reset, start_stop, 250 tick_in periods -> disp=16'h0250, running=1, ovf never asserted.
REQ-032 SHALL cover: count preloaded to 59.99 in RUN, one tick -> disp=16'h0000, ovf high exactly 1 cycle, running=1.
REQ-033 SHALL cover: RUN at 00.07, start_stop coincident with tick_rise -> disp=16'h0008, state PAUSE; further ticks leave disp=16'h0008.
REQ-034 SHALL cover: PAUSE at 12.34, start_stop+clear in the same cycle -> IDLE, disp=16'h0000; clear asserted in RUN -> no effect.
REQ-035 SHALL cover: rst_n pulsed low mid-RUN at 03.21 -> outputs zero immediately (asynchronously); ticks after release leave disp=16'h0000.
REQ-036 SHALL cover (STOPWATCH_LAP_EN): lap at 01.00, 50 ticks -> disp=16'h0100, lap_hold=1; second lap -> disp=16'h0150, lap_hold=0.
